fpu_divider: RTL and testbench

- Multi-cycle IEEE-754 single-precision floating-point divider: quotient = dividend / divisor.
- Operands are held static while reset is asserted. Computation starts on reset release.
- The result appears on quotient after a fixed latency and holds until the next reset.
- Used as a standalone arithmetic unit; there is no start/valid handshake in the base configuration.

---
 rtl/fpu_divider.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_divider.sv
// Multi-cycle IEEE-754 single-precision divider: quotient = dividend / divisor.
// Optional FPU_STATUS_EN adds done/special status outputs.
module fpu_divider #(
  parameter int ITER = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient
`ifdef FPU_STATUS_EN
  ,
  output logic        done,
  output logic [3:0]  special
`endif
);
  localparam int MW = ITER + 1;  // quotient bits plus sticky
  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {LOAD, CLASSIFY, NORM, DIV, ROUND, DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_a, r_b, r_quot;
  logic               r_s;
  logic [23:0]        r_ma, r_mb, r_div;
  logic signed [9:0]  r_ea, r_eb, r_e;
  logic [24:0]        r_rem;
  logic [ITER-1:0]    r_q;
  logic [CW-1:0]      r_cnt;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (m[i]) lzc24 = 5'(23 - i);
  endfunction

  // Classification of the latched operands
  logic [7:0]  w_xa, w_xb;
  logic [22:0] w_fa, w_fb;
  logic        w_s, w_za, w_zb, w_ia, w_ib, w_nana, w_nanb;
  logic [3:0]  w_spc;
  logic [31:0] w_sres;
  always_comb begin
    w_xa   = r_a[30:23];
    w_xb   = r_b[30:23];
    w_fa   = r_a[22:0];
    w_fb   = r_b[22:0];
    w_s    = r_a[31] ^ r_b[31];
    w_za   = (w_xa == 8'h00) && (w_fa == 23'h0);
    w_zb   = (w_xb == 8'h00) && (w_fb == 23'h0);
    w_ia   = (w_xa == 8'hFF) && (w_fa == 23'h0);
    w_ib   = (w_xb == 8'hFF) && (w_fb == 23'h0);
    w_nana = (w_xa == 8'hFF) && (w_fa != 23'h0);
    w_nanb = (w_xb == 8'hFF) && (w_fb != 23'h0);
    w_spc  = 4'd0;
    w_sres = 32'h0;
    if (w_nana || w_nanb) begin
      w_spc = 4'd5; w_sres = 32'h7FC00000;
    end else if (w_za && w_zb) begin
      w_spc = 4'd3; w_sres = 32'h7FC00000;
    end else if (w_ia && w_ib) begin
      w_spc = 4'd4; w_sres = 32'h7FC00000;
    end else if (w_ia && w_zb) begin
      w_spc = 4'd6; w_sres = {w_s, 8'hFF, 23'h0};
    end else if (w_ia) begin
      w_spc = 4'd7; w_sres = {w_s, 8'hFF, 23'h0};
    end else if (w_zb) begin
      w_spc = 4'd2; w_sres = {w_s, 8'hFF, 23'h0};
    end else if (w_ib) begin
      w_spc = 4'd1; w_sres = {w_s, 31'h0};
    end else if (w_za) begin
      w_spc = 4'd8; w_sres = {w_s, 31'h0};
    end
  end

  // Leading-one normalize; pre-shift keeps the first quotient bit at 1
  logic [4:0]        w_lza, w_lzb;
  logic [23:0]       w_na, w_nb;
  logic signed [9:0] w_ean, w_ebn, w_e0;
  logic              w_pre;
  always_comb begin
    w_lza = lzc24(r_ma);
    w_lzb = lzc24(r_mb);
    w_na  = r_ma << w_lza;
    w_nb  = r_mb << w_lzb;
    w_ean = r_ea - $signed({5'b0, w_lza});
    w_ebn = r_eb - $signed({5'b0, w_lzb});
    w_pre = w_na < w_nb;
    w_e0  = w_ean - w_ebn + 10'sd127 - $signed({9'b0, w_pre});
  end

  logic        w_ge;
  logic [24:0] w_diff, w_rnext;
  always_comb begin
    w_ge    = r_rem >= {1'b0, r_div};
    w_diff  = r_rem - {1'b0, r_div};
    w_rnext = (w_ge ? w_diff : r_rem) << 1;
  end

  // Rounding with gradual underflow
  logic [MW-1:0]     w_m, w_mask, w_shm;
  logic [9:0]        w_sh;
  logic              w_sub, w_lost, w_g, w_st, w_up, w_ovf, w_unf;
  logic [24:0]       w_sum;
  logic signed [9:0] w_en;
  logic [31:0]       w_res;
  always_comb begin
    w_m    = {r_q, |r_rem};
    w_sub  = r_e <= 10'sd0;
    w_sh   = 10'd1 - r_e;
    w_mask = (MW'(1) << w_sh) - MW'(1);
    w_shm  = w_m;
    w_lost = 1'b0;
    if (w_sub) begin
      w_shm  = w_m >> w_sh;
      w_lost = |(w_m & w_mask);
    end
    w_g   = w_shm[MW-25];
    w_st  = (|w_shm[MW-26:0]) | w_lost;
    w_up  = w_g & (w_st | w_shm[MW-24]);
    w_sum = {1'b0, w_shm[MW-1:MW-24]} + {24'b0, w_up};
    w_en  = r_e + $signed({9'b0, w_sum[24]});
    w_ovf = !w_sub && (w_en >= 10'sd255);
    w_unf = w_sub && ((w_sh > 10'd25) || (w_sum == 25'd0));
    if (w_ovf)      w_res = {r_s, 8'hFF, 23'h0};
    else if (w_unf) w_res = {r_s, 31'h0};
    else if (w_sub) w_res = {r_s, 7'h0, w_sum[23:0]};
    else            w_res = {r_s, w_en[7:0], w_sum[22:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
      r_a     <= '0;
      r_b     <= '0;
      r_quot  <= '0;
      r_s     <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_div   <= '0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_e     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_a     <= dividend;
          r_b     <= divisor;
          r_state <= CLASSIFY;
        end
        CLASSIFY: begin
          r_s <= w_s;
          if (w_spc != 4'd0) begin
            r_quot  <= w_sres;
            r_state <= DONE;
          end else begin
            r_ma    <= {w_xa != 8'h00, w_fa};
            r_mb    <= {w_xb != 8'h00, w_fb};
            r_ea    <= (w_xa == 8'h00) ? 10'sd1 : $signed({2'b0, w_xa});
            r_eb    <= (w_xb == 8'h00) ? 10'sd1 : $signed({2'b0, w_xb});
            r_state <= NORM;
          end
        end
        NORM: begin
          r_rem   <= w_pre ? {w_na, 1'b0} : {1'b0, w_na};
          r_div   <= w_nb;
          r_e     <= w_e0;
          r_q     <= '0;
          r_cnt   <= '0;
          r_state <= DIV;
        end
        DIV: begin
          r_rem <= w_rnext;
          r_q   <= {r_q[ITER-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ITER - 1)) r_state <= ROUND;
        end
        ROUND: begin
          r_quot  <= w_res;
          r_state <= DONE;
        end
        default: r_state <= DONE;
      endcase
    end
  end

  assign quotient = r_quot;

`ifdef FPU_STATUS_EN
  logic       r_done;
  logic [3:0] r_code;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_code <= 4'd0;
    end else if (r_state == CLASSIFY && w_spc != 4'd0) begin
      r_done <= 1'b1;
      r_code <= w_spc;
    end else if (r_state == ROUND) begin
      r_done <= 1'b1;
      r_code <= w_ovf ? 4'd9 : (w_unf ? 4'd10 : 4'd0);
    end
  end
  assign done    = r_done;
  assign special = r_code;
`endif
endmodule

// File: tb/tb_fpu_divider.sv
// Scoreboard bench for fpu_divider: expected {code,quotient} queued at launch,
// popped and compared when the result is due.
module tb_fpu_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor  = '0;
  logic [31:0] quotient;
`ifdef FPU_STATUS_EN
  logic        done;
  logic [3:0]  special;
`endif

  int errors = 0;
  int checks = 0;
  logic [35:0] sb[$];

  fpu_divider #(.ITER(27)) dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
    .quotient(quotient)
`ifdef FPU_STATUS_EN
    , .done(done), .special(special)
`endif
  );

  always #5 clk = ~clk;

  // Reset with operands applied, then release; next rising edge is edge 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [3:0] c);
    @(negedge clk);
    rst = 1'b0; dividend = a; divisor = b;
    sb.push_back({c, q});
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dividend = 32'h3FC00000; divisor = 32'h3F000000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 32'h0) begin
      errors++; $display("FAIL reset_quot got=%h exp=%h", quotient, 32'h0);
    end
`ifdef FPU_STATUS_EN
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", done);
    end
`endif
  endtask

  task automatic test_normal();
    logic [31:0] ta[9], tb[9], tq[9];
    logic [3:0]  tc[9];
    logic [35:0] e;
    ta = '{32'h3FC00000, 32'h3F000000, 32'h004A0000, 32'h3FC00000, 32'h00560000,
           32'h207C0000, 32'h41A00000, 32'h01A00000, 32'hBFC00000};
    tb = '{32'h3F000000, 32'h3FC00000, 32'h3FC00000, 32'h00560000, 32'h00400000,
           32'h5FC90000, 32'h01A00000, 32'h4FA00000, 32'h3F000000};
    tq = '{32'h40400000, 32'h3EAAAAAB, 32'h00315555, 32'h7F0EE23C, 32'h3FAC0000,
           32'h00503D22, 32'h7F800000, 32'h00000000, 32'hC0400000};
    tc = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd10, 4'd0};
    for (int i = 0; i < 9; i++) begin
      start_op(ta[i], tb[i], tq[i], tc[i]);
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (quotient !== 32'h0) begin
        errors++; $display("FAIL normal_early[%0d] got=%h exp=%h", i, quotient, 32'h0);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (quotient !== e[31:0]) begin
        errors++; $display("FAIL normal_quot[%0d] got=%h exp=%h", i, quotient, e[31:0]);
      end
`ifdef FPU_STATUS_EN
      checks++;
      if (done !== 1'b1 || special !== e[35:32]) begin
        errors++; $display("FAIL normal_status[%0d] got=%b/%0d exp=1/%0d", i, done, special, e[35:32]);
      end
`endif
    end
  endtask

  task automatic test_special();
    logic [31:0] ta[12], tb[12], tq[12];
    logic [3:0]  tc[12];
    logic [35:0] e;
    ta = '{32'h3FC00000, 32'h3FC00000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3FC00000,
           32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h00000000, 32'hBFC00000, 32'h3FC00000};
    tb = '{32'h7F800000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
           32'h7FC00000, 32'h00000000, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 32'hFF800000};
    tq = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
           32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h00000000, 32'hFF800000, 32'h80000000};
    tc = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd1};
    for (int i = 0; i < 12; i++) begin
      start_op(ta[i], tb[i], tq[i], tc[i]);
      repeat (31) @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (quotient !== e[31:0]) begin
        errors++; $display("FAIL special_quot[%0d] got=%h exp=%h", i, quotient, e[31:0]);
      end
`ifdef FPU_STATUS_EN
      checks++;
      if (done !== 1'b1 || special !== e[35:32]) begin
        errors++; $display("FAIL special_status[%0d] got=%b/%0d exp=1/%0d", i, done, special, e[35:32]);
      end
`endif
    end
  endtask

  task automatic test_abort();
    logic [35:0] e;
    // Finish one run, then reset between edges: result must clear at once.
    start_op(32'h3FC00000, 32'h3F000000, 32'h40400000, 4'd0);
    repeat (31) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (quotient !== e[31:0]) begin
      errors++; $display("FAIL abort_pre got=%h exp=%h", quotient, e[31:0]);
    end
    repeat (5) @(posedge clk);
    #1;
    dividend = 32'h12345678;
    checks++;
    if (quotient !== e[31:0]) begin
      errors++; $display("FAIL hold got=%h exp=%h", quotient, e[31:0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (quotient !== 32'h0) begin
      errors++; $display("FAIL async_clear got=%h exp=%h", quotient, 32'h0);
    end
    // Abort in the middle of DIV; the queued result is dropped.
    start_op(32'h41A00000, 32'h3FC00000, 32'h0, 4'd0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_front());
    #1;
    checks++;
    if (quotient !== 32'h0) begin
      errors++; $display("FAIL abort_mid got=%h exp=%h", quotient, 32'h0);
    end
    // Rerun; operands disturbed after LOAD must be ignored.
    start_op(32'h3F000000, 32'h3FC00000, 32'h3EAAAAAB, 4'd0);
    @(posedge clk);
    #1 dividend = 32'h12345678; divisor = 32'h00000000;
    repeat (29) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 32'h0) begin
      errors++; $display("FAIL rerun_early got=%h exp=%h", quotient, 32'h0);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (quotient !== e[31:0]) begin
      errors++; $display("FAIL rerun_quot got=%h exp=%h", quotient, e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
